// File: rtl/mac_index_sequencer_pkg.sv
// Shared definitions for the MAC index sequencer and the layer controller.
// Holds the sequencer state encoding and the default index width.
package mac_index_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int IDX_W_DEFAULT = 4;

endpackage

// File: rtl/mac_index_sequencer_wrap_counter.sv
// Wrapping index counter that counts 0..MAX and flags the terminal value.
// Ports: i_clk, i_rst (async, active-high), i_clear, i_inc -> o_count, o_at_max.
// The wrap happens by comparison with MAX, so any MAX below 2**W is exact.
module mac_index_sequencer_wrap_counter #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] r_count;

    // Clear outranks increment, so a wrap and a restart look the same.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count  = r_count;
    assign o_at_max = (r_count == MAX_V);

endmodule

// File: rtl/mac_index_sequencer.sv
// Generates the row-major (out_idx, in_idx) stream for one FC layer's MAC.
// Ports: i_clk, i_rst, i_start, i_abort, i_ready -> o_valid, o_in_idx,
//        o_out_idx, o_first_in, o_last_in, o_busy, o_done.
module mac_index_sequencer
    import mac_index_sequencer_pkg::*;
#(
    parameter int IDX_W     = IDX_W_DEFAULT,
    parameter int IN_COUNT  = 16,
    parameter int OUT_COUNT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_in_idx,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_first_in,
    output logic             o_last_in,
    output logic             o_busy,
    output logic             o_done
);

    seq_state_t r_state;
    logic       r_valid;
    logic       r_busy;
    logic       r_done;

    logic             w_launch;
    logic             w_abort;
    logic             w_fire;
    logic             w_last_pair;
    logic             w_clr;
    logic             w_in_max;
    logic             w_out_max;
    logic             w_row_step;
    logic [IDX_W-1:0] w_in_idx;
    logic [IDX_W-1:0] w_out_idx;

    // Abort only matters once a run is active; in IDLE it also vetoes start.
    assign w_launch    = (r_state == ST_IDLE) && i_start && !i_abort;
    assign w_abort     = (r_state != ST_IDLE) && i_abort;
    assign w_fire      = (r_state == ST_RUN) && r_valid && i_ready && !i_abort;
    assign w_last_pair = w_fire && w_in_max && w_out_max;
    assign w_row_step  = w_fire && w_in_max && !w_out_max;
    assign w_clr       = w_launch || w_abort;

    // The final fire leaves both counters alone so the last pair stays visible.
    mac_index_sequencer_wrap_counter #(
        .W   (IDX_W),
        .MAX (IN_COUNT - 1)
    ) u_in_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clr || w_row_step),
        .i_inc    (w_fire && !w_in_max),
        .o_count  (w_in_idx),
        .o_at_max (w_in_max)
    );

    mac_index_sequencer_wrap_counter #(
        .W   (IDX_W),
        .MAX (OUT_COUNT - 1)
    ) u_out_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clear  (w_clr),
        .i_inc    (w_row_step),
        .o_count  (w_out_idx),
        .o_at_max (w_out_max)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_launch) begin
                        r_state <= ST_RUN;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_last_pair) begin
                        r_state <= ST_DONE;
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_valid    = r_valid;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_in_idx   = w_in_idx;
    assign o_out_idx  = w_out_idx;
    assign o_first_in = r_valid && (w_in_idx == '0);
    assign o_last_in  = r_valid && w_in_max;

endmodule

// File: tb/tb_mac_index_sequencer.sv
// Scoreboard bench for mac_index_sequencer: three parameterisations
// (16x16, 3x5, 1x1) driven one at a time against a row-major pair model.
module tb_mac_index_sequencer;

    typedef struct packed {
        logic [3:0] o;
        logic [3:0] i;
        logic       f;
        logic       l;
    } exp_t;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       start_r   = 1'b0;
    logic       abort_r   = 1'b0;
    logic       ready_r   = 1'b0;
    logic       rnd_ready = 1'b0;
    logic [1:0] sel       = 2'd0;

    logic [2:0] st_v;
    logic [2:0] v;
    logic [2:0] fi;
    logic [2:0] la;
    logic [2:0] bz;
    logic [2:0] dn;
    logic [3:0] ii [3];
    logic [3:0] oi [3];

    exp_t exp_q [$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    assign st_v = start_r ? 3'(3'b001 << sel) : 3'b000;

    mac_index_sequencer #(.IDX_W(4), .IN_COUNT(16), .OUT_COUNT(16)) u0 (
        .i_clk(clk), .i_rst(rst), .i_start(st_v[0]), .i_abort(abort_r),
        .i_ready(ready_r), .o_valid(v[0]), .o_in_idx(ii[0]),
        .o_out_idx(oi[0]), .o_first_in(fi[0]), .o_last_in(la[0]),
        .o_busy(bz[0]), .o_done(dn[0])
    );

    mac_index_sequencer #(.IDX_W(4), .IN_COUNT(3), .OUT_COUNT(5)) u1 (
        .i_clk(clk), .i_rst(rst), .i_start(st_v[1]), .i_abort(abort_r),
        .i_ready(ready_r), .o_valid(v[1]), .o_in_idx(ii[1]),
        .o_out_idx(oi[1]), .o_first_in(fi[1]), .o_last_in(la[1]),
        .o_busy(bz[1]), .o_done(dn[1])
    );

    mac_index_sequencer #(.IDX_W(4), .IN_COUNT(1), .OUT_COUNT(1)) u2 (
        .i_clk(clk), .i_rst(rst), .i_start(st_v[2]), .i_abort(abort_r),
        .i_ready(ready_r), .o_valid(v[2]), .o_in_idx(ii[2]),
        .o_out_idx(oi[2]), .o_first_in(fi[2]), .o_last_in(la[2]),
        .o_busy(bz[2]), .o_done(dn[2])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, req);
    endtask

    // Reference: a layer is every (row, col) pair in row-major order;
    // lim truncates the list for runs that get cancelled.
    task automatic push_run(input int ic, input int oc, input int lim);
        int   k;
        exp_t e;
        k = 0;
        for (int o = 0; o < oc; o++) begin
            for (int i = 0; i < ic; i++) begin
                if (k < lim) begin
                    e.o = 4'(o);
                    e.i = 4'(i);
                    e.f = (i == 0);
                    e.l = (i == ic - 1);
                    exp_q.push_back(e);
                end
                k++;
            end
        end
    endtask

    task automatic go(input int ic, input int oc, input int lim);
        push_run(ic, oc, lim);
        @(posedge clk);
        #1 start_r = 1'b1;
    endtask

    // n counts edges from the one that samples start to the one that raises done.
    task automatic wait_done(input int lim, output int n);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            #1 start_r = 1'b0;
            @(negedge clk);
        end while (!dn[sel] && n < lim);
        if (!dn[sel]) chk("done_timeout", 32'(dn[sel]), 32'd1);
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_ready) ready_r = 1'($urandom_range(0, 1));
    end

    // Monitor: pops one expected pair per accepted handshake and
    // checks that a stalled pair is still presented on the next cycle.
    initial begin : monitor
        logic       hold_pend;
        logic [9:0] hold_val;
        logic [9:0] cur;
        exp_t       e;
        hold_pend = 1'b0;
        hold_val  = '0;
        forever begin
            @(negedge clk);
            cur = {oi[sel], ii[sel], fi[sel], la[sel]};
            if (hold_pend && !rst)
                chk("hold", 32'({v[sel], cur}), 32'({1'b1, hold_val}));
            hold_pend = 1'b0;
            if (dn[sel]) done_cnt++;
            if (v[sel] && ready_r && !abort_r && !rst) begin
                if (exp_q.size() == 0) begin
                    chk("extra_fire", 32'(v[sel]), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair", 32'(cur), 32'(e));
                end
            end
            if (v[sel] && !ready_r && !abort_r && !rst) begin
                hold_pend = 1'b1;
                hold_val  = cur;
            end
        end
    end

    initial begin : stim
        int n;
        int d;

        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++)
            chk("reset_state",
                32'({v[k], bz[k], dn[k], fi[k], la[k], oi[k], ii[k]}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Full default layer with the MAC always ready.
        @(posedge clk);
        #2 sel = 2'd0; ready_r = 1'b1;
        d = done_cnt;
        go(16, 16, 256);
        wait_done(400, n);
        chk("t1_latency", 32'(n), 32'd257);
        chk("t1_busy_at_done", 32'(bz[0]), 32'd1);
        chk("t1_last_idx", 32'({oi[0], ii[0]}), 32'hFF);
        chk("t1_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("t1_done_pulse", 32'({dn[0], bz[0], v[0]}), 32'd0);
        chk("t1_done_count", 32'(done_cnt - d), 32'd1);

        // 3x5 layer with random back-pressure.
        @(posedge clk);
        #2 sel = 2'd1; rnd_ready = 1'b1;
        d = done_cnt;
        go(3, 5, 15);
        wait_done(300, n);
        chk("t2_drain", 32'(exp_q.size()), 32'd0);
        chk("t2_last_idx", 32'({oi[1], ii[1]}), 32'h42);
        chk("t2_done_count", 32'(done_cnt - d), 32'd1);

        // Start re-pulsed in RUN and in DONE must not restart.
        d = done_cnt;
        go(3, 5, 15);
        @(posedge clk);
        #1 start_r = 1'b0;
        repeat (3) @(posedge clk);
        #1 start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        wait_done(300, n);
        start_r = 1'b1;
        @(posedge clk);
        #1 start_r = 1'b0;
        repeat (6) @(negedge clk);
        chk("t3_no_restart", 32'({v[1], bz[1]}), 32'd0);
        chk("t3_done_count", 32'(done_cnt - d), 32'd1);
        chk("t3_drain", 32'(exp_q.size()), 32'd0);

        // Abort on pair (2,7) while ready is high.
        @(posedge clk);
        #2 sel = 2'd0; rnd_ready = 1'b0; ready_r = 1'b1;
        d = done_cnt;
        go(16, 16, 39);
        n = 0;
        do begin
            @(posedge clk);
            #1 start_r = 1'b0;
            n++;
        end while (!(v[0] && oi[0] == 4'd2 && ii[0] == 4'd7) && n < 200);
        chk("t4_reach", 32'({v[0], oi[0], ii[0]}), 32'h127);
        abort_r = 1'b1;
        @(posedge clk);
        #1 abort_r = 1'b0;
        chk("t4_idle", 32'({v[0], bz[0], dn[0], oi[0], ii[0]}), 32'd0);
        repeat (5) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt - d), 32'd0);
        chk("t4_drain", 32'(exp_q.size()), 32'd0);
        go(16, 16, 256);
        wait_done(400, n);
        chk("t4_restart_lat", 32'(n), 32'd257);
        chk("t4_restart_drain", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a 3x5 run.
        @(posedge clk);
        #2 sel = 2'd1; rnd_ready = 1'b1;
        d = done_cnt;
        go(3, 5, 15);
        @(posedge clk);
        #1 start_r = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t5_async", 32'({v[1], bz[1], dn[1], oi[1], ii[1]}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        go(3, 5, 15);
        wait_done(300, n);
        chk("t5_drain", 32'(exp_q.size()), 32'd0);
        chk("t5_done_count", 32'(done_cnt - d), 32'd1);

        // Single-pair layer.
        @(posedge clk);
        #2 sel = 2'd2; rnd_ready = 1'b0; ready_r = 1'b1;
        d = done_cnt;
        go(1, 1, 1);
        wait_done(20, n);
        chk("t6_latency", 32'(n), 32'd2);
        chk("t6_drain", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        chk("t6_done_pulse", 32'({dn[2], bz[2]}), 32'd0);
        chk("t6_done_count", 32'(done_cnt - d), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
